fetch_unit: RTL



---
 rtl/fetch_unit.sv | 95 +++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues one imem word request at a time and holds
// the returned word in a one-entry buffer until IF/ID accepts it.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        ValidF
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] req_pc_q;
    logic        buf_valid_q;
    logic [31:0] buf_instr_q;
    logic [31:0] buf_pc_q;
    logic        drop_q;

    logic consume;
    logic free;

    assign consume   = buf_valid_q & enable & ~redirect;
    assign free      = ~buf_valid_q | consume;
    assign imem_req  = (state_q == S_REQ) & free & ~redirect;
    assign imem_addr = pc_q;

    assign ValidF   = buf_valid_q;
    assign InstrF   = buf_valid_q ? buf_instr_q : NOP_INSTR;
    assign PCF      = buf_valid_q ? buf_pc_q : 32'h0;
    assign PCPlus4F = buf_valid_q ? (buf_pc_q + 32'd4) : 32'h0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            req_pc_q    <= RESET_PC;
            buf_valid_q <= 1'b0;
            buf_instr_q <= NOP_INSTR;
            buf_pc_q    <= 32'h0;
            drop_q      <= 1'b0;
        end else begin
            if (consume) begin
                buf_valid_q <= 1'b0;
            end
            unique case (state_q)
                S_IDLE: begin
                    state_q <= S_REQ;
                end
                S_REQ: begin
                    if (imem_req && imem_ready) begin
                        req_pc_q <= pc_q;
                        pc_q     <= pc_q + 32'd4;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_q <= S_REQ;
                        drop_q  <= 1'b0;
                        // A word is kept only if neither an older nor a same-cycle redirect stales it.
                        if (!drop_q && !redirect) begin
                            buf_valid_q <= 1'b1;
                            buf_instr_q <= imem_rdata;
                            buf_pc_q    <= req_pc_q;
                        end
                    end else if (redirect) begin
                        drop_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
            if (redirect) begin
                buf_valid_q <= 1'b0;
                pc_q        <= {redirect_pc[31:2], 2'b00};
            end
        end
    end

endmodule
